// File: rtl/masked_sbox_arbiter_pkg.sv
// Shared constants and shadow-entry layout for the masked S-box arbiter.
package masked_sbox_arbiter_pkg;

  localparam int DEF_LATENCY = 3;
  localparam int DEF_TAG_W   = 4;
  localparam int BYTE_W      = 8;

  typedef struct packed {
    logic                 valid;
    logic                 port;
    logic [DEF_TAG_W-1:0] tag;
  } shadow_entry_t;

  localparam int SHADOW_W = $bits(shadow_entry_t);

endpackage

// File: rtl/sbox_tag_pipe.sv
// Fixed-depth shadow pipeline: follows each S-box issue with its port/tag so
// results can be steered when they emerge. Never stalls.
module sbox_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             any_valid
);

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] data_p [DEPTH];

  // Valid bits are control and are cleared by reset; payload is not.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    data_p[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) begin
      data_p[i] <= data_p[i-1];
    end
  end

  assign out_valid = vld_p[DEPTH-1];
  assign out_data  = data_p[DEPTH-1];
  assign any_valid = |vld_p;

endmodule

// File: rtl/masked_sbox_arbiter.sv
// Round-robin arbiter sharing one masked S-box between two requesters; an
// issue needs fresh randomness, results return LATENCY cycles later.
module masked_sbox_arbiter
  import masked_sbox_arbiter_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [BYTE_W-1:0] req0_s0,
  input  logic [BYTE_W-1:0] req0_s1,
  input  logic [TAG_W-1:0]  req0_tag,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [BYTE_W-1:0] req1_s0,
  input  logic [BYTE_W-1:0] req1_s1,
  input  logic [TAG_W-1:0]  req1_tag,

  input  logic              fresh_valid,
  input  logic [BYTE_W-1:0] fresh,
  output logic              fresh_ack,

  output logic [BYTE_W-1:0] sbox_X_s0,
  output logic [BYTE_W-1:0] sbox_X_s1,
  output logic [BYTE_W-1:0] sbox_Fresh,
  input  logic [BYTE_W-1:0] sbox_Y_s0,
  input  logic [BYTE_W-1:0] sbox_Y_s1,

  output logic              rsp0_valid,
  output logic [BYTE_W-1:0] rsp0_s0,
  output logic [BYTE_W-1:0] rsp0_s1,
  output logic [TAG_W-1:0]  rsp0_tag,

  output logic              rsp1_valid,
  output logic [BYTE_W-1:0] rsp1_s0,
  output logic [BYTE_W-1:0] rsp1_s1,
  output logic [TAG_W-1:0]  rsp1_tag,

  output logic              busy
);

  localparam int PIPE_W = TAG_W + 1;

  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic              issue;
  logic [TAG_W-1:0]  issue_tag;
  logic [PIPE_W-1:0] issue_entry;
  logic              pipe_valid;
  logic [PIPE_W-1:0] pipe_data;
  logic              pipe_any;
  logic              out_port;
  logic [TAG_W-1:0]  out_tag;

  // Grants are forced low during reset so nothing leaks onto the S-box port.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && fresh_valid) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign issue = grant0 | grant1;

  // last_grant = 1 means port 1 won most recently, so port 0 wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (issue) begin
      last_grant <= grant1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign fresh_ack  = issue;

  always_comb begin
    sbox_X_s0  = '0;
    sbox_X_s1  = '0;
    sbox_Fresh = '0;
    issue_tag  = '0;
    if (grant0) begin
      sbox_X_s0  = req0_s0;
      sbox_X_s1  = req0_s1;
      sbox_Fresh = fresh;
      issue_tag  = req0_tag;
    end else if (grant1) begin
      sbox_X_s0  = req1_s0;
      sbox_X_s1  = req1_s1;
      sbox_Fresh = fresh;
      issue_tag  = req1_tag;
    end
  end

  assign issue_entry = {grant1, issue_tag};

  sbox_tag_pipe #(
    .DEPTH (LATENCY),
    .WIDTH (PIPE_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_data   (issue_entry),
    .out_valid (pipe_valid),
    .out_data  (pipe_data),
    .any_valid (pipe_any)
  );

  assign out_port = pipe_data[TAG_W];
  assign out_tag  = pipe_data[TAG_W-1:0];

  // Results are steered to the issuing port; idle response buses read zero.
  assign rsp0_valid = !rst && pipe_valid && !out_port;
  assign rsp1_valid = !rst && pipe_valid && out_port;
  assign rsp0_s0    = rsp0_valid ? sbox_Y_s0 : '0;
  assign rsp0_s1    = rsp0_valid ? sbox_Y_s1 : '0;
  assign rsp0_tag   = rsp0_valid ? out_tag : '0;
  assign rsp1_s0    = rsp1_valid ? sbox_Y_s0 : '0;
  assign rsp1_s1    = rsp1_valid ? sbox_Y_s1 : '0;
  assign rsp1_tag   = rsp1_valid ? out_tag : '0;

  assign busy = !rst && pipe_any;

endmodule

// File: tb/tb_masked_sbox_arbiter.sv
// Directed bench for masked_sbox_arbiter with a 3-stage masked AES S-box model.
module tb_masked_sbox_arbiter;

  localparam int LAT = 3;
  localparam int TW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          req0_valid = 1'b0, req0_ready;
  logic [7:0]    req0_s0 = '0, req0_s1 = '0;
  logic [TW-1:0] req0_tag = '0;
  logic          req1_valid = 1'b0, req1_ready;
  logic [7:0]    req1_s0 = '0, req1_s1 = '0;
  logic [TW-1:0] req1_tag = '0;
  logic          fresh_valid = 1'b0, fresh_ack;
  logic [7:0]    fresh = '0;
  logic [7:0]    sbox_X_s0, sbox_X_s1, sbox_Fresh, sbox_Y_s0, sbox_Y_s1;
  logic          rsp0_valid, rsp1_valid, busy;
  logic [7:0]    rsp0_s0, rsp0_s1, rsp1_s0, rsp1_s1;
  logic [TW-1:0] rsp0_tag, rsp1_tag;

  int n_checks = 0;
  int n_fail   = 0;

  masked_sbox_arbiter #(.LATENCY(LAT), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_s0(req0_s0), .req0_s1(req0_s1), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_s0(req1_s0), .req1_s1(req1_s1), .req1_tag(req1_tag),
    .fresh_valid(fresh_valid), .fresh(fresh), .fresh_ack(fresh_ack),
    .sbox_X_s0(sbox_X_s0), .sbox_X_s1(sbox_X_s1), .sbox_Fresh(sbox_Fresh),
    .sbox_Y_s0(sbox_Y_s0), .sbox_Y_s1(sbox_Y_s1),
    .rsp0_valid(rsp0_valid), .rsp0_s0(rsp0_s0), .rsp0_s1(rsp0_s1), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_s0(rsp1_s0), .rsp1_s1(rsp1_s1), .rsp1_tag(rsp1_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (gmul(x, 8'(b)) == 8'h01) inv = 8'(b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Masked S-box model: output shares {S(x)^fresh, fresh} after LAT registers.
  logic [7:0] ys0_p [LAT];
  logic [7:0] ys1_p [LAT];
  always @(posedge clk) begin
    ys0_p[0] <= aes_sbox(sbox_X_s0 ^ sbox_X_s1) ^ sbox_Fresh;
    ys1_p[0] <= sbox_Fresh;
    for (int i = 1; i < LAT; i++) begin
      ys0_p[i] <= ys0_p[i-1];
      ys1_p[i] <= ys1_p[i-1];
    end
  end
  assign sbox_Y_s0 = ys0_p[LAT-1];
  assign sbox_Y_s1 = ys1_p[LAT-1];

  task automatic drive_idle();
    req0_valid = 1'b0; req0_s0 = '0; req0_s1 = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_s0 = '0; req1_s1 = '0; req1_tag = '0;
    fresh_valid = 1'b0; fresh = '0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1; req0_s0 = 8'h11; req0_s1 = 8'h22; req0_tag = 4'h1;
    req1_valid = 1'b1; req1_s0 = 8'h33; req1_s1 = 8'h44; req1_tag = 4'h2;
    fresh_valid = 1'b1; fresh = 8'h77;
    #2;
    n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset req0_ready got=%b exp=0", req0_ready); end
    n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset req1_ready got=%b exp=0", req1_ready); end
    n_checks++; if (fresh_ack !== 1'b0) begin n_fail++; $display("FAIL reset fresh_ack got=%b exp=0", fresh_ack); end
    n_checks++; if ({sbox_X_s0, sbox_X_s1, sbox_Fresh} !== 24'h0) begin n_fail++; $display("FAIL reset sbox_drive got=%h exp=0", {sbox_X_s0, sbox_X_s1, sbox_Fresh}); end
    n_checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL reset rsp_busy got=%b exp=000", {rsp0_valid, rsp1_valid, busy}); end
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
  endtask

  task automatic test_single();
    reset_dut();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive_idle();
      if (c == 0) begin
        req0_valid = 1'b1; req0_s0 = 8'h53 ^ 8'hA5; req0_s1 = 8'hA5; req0_tag = 4'd3;
        req1_s0 = 8'hEE; req1_s1 = 8'hDD;
        fresh_valid = 1'b1; fresh = 8'h5A;
      end
      #2;
      if (c == 0) begin
        n_checks++; if ({req0_ready, req1_ready, fresh_ack} !== 3'b101) begin n_fail++; $display("FAIL single handshake got=%b exp=101", {req0_ready, req1_ready, fresh_ack}); end
        n_checks++; if ({sbox_X_s0, sbox_X_s1, sbox_Fresh} !== 24'hF6A55A) begin n_fail++; $display("FAIL single sbox_drive got=%h exp=f6a55a", {sbox_X_s0, sbox_X_s1, sbox_Fresh}); end
      end else if (c < 3) begin
        n_checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b001) begin n_fail++; $display("FAIL single inflight c=%0d got=%b exp=001", c, {rsp0_valid, rsp1_valid, busy}); end
      end else if (c == 3) begin
        n_checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin n_fail++; $display("FAIL single rsp_valid got=%b exp=10", {rsp0_valid, rsp1_valid}); end
        n_checks++; if ((rsp0_s0 ^ rsp0_s1) !== 8'hED) begin n_fail++; $display("FAIL single rsp0_data got=%h exp=ed", rsp0_s0 ^ rsp0_s1); end
        n_checks++; if (rsp0_tag !== 4'd3) begin n_fail++; $display("FAIL single rsp0_tag got=%0d exp=3", rsp0_tag); end
        n_checks++; if ({rsp1_s0, rsp1_s1, rsp1_tag} !== 20'h0) begin n_fail++; $display("FAIL single rsp1_idle got=%h exp=0", {rsp1_s0, rsp1_s1, rsp1_tag}); end
      end else begin
        n_checks++; if ({rsp0_valid, busy, rsp0_s0, rsp0_s1, rsp0_tag} !== 22'h0) begin n_fail++; $display("FAIL single after got=%h exp=0", {rsp0_valid, busy, rsp0_s0, rsp0_s1, rsp0_tag}); end
      end
    end
  endtask

  // Both ports request every cycle; exp_g is the hand-derived grant per cycle (-1 = none).
  task automatic test_stream(input string name, input int n, input int exp_g [8], input logic fv [8]);
    logic       ev [16];
    int         ep [16];
    logic [3:0] et [16];
    logic [7:0] eb [16];
    logic [7:0] b0, b1, m0, m1, got;
    logic       e0, e1;
    logic [3:0] gtag;
    int         k;
    reset_dut();
    for (int c = 0; c < n + LAT + 1; c++) begin
      @(negedge clk);
      drive_idle();
      b0 = 8'h10 + 8'(c); m0 = 8'h3C ^ 8'(c * 7);
      b1 = 8'h80 + 8'(c); m1 = 8'hC3 ^ 8'(c * 5);
      if (c < n) begin
        req0_valid = 1'b1; req0_s0 = b0 ^ m0; req0_s1 = m0; req0_tag = 4'(c);
        req1_valid = 1'b1; req1_s0 = b1 ^ m1; req1_s1 = m1; req1_tag = 4'(8 + c);
        fresh_valid = fv[c]; fresh = 8'hC0 + 8'(c);
      end
      ev[c] = (c < n) && (exp_g[c] >= 0);
      ep[c] = (c < n) ? exp_g[c] : -1;
      et[c] = (ep[c] == 1) ? 4'(8 + c) : 4'(c);
      eb[c] = (ep[c] == 1) ? aes_sbox(b1) : aes_sbox(b0);
      #2;
      n_checks++; if (req0_ready !== (ep[c] == 0)) begin n_fail++; $display("FAIL %s ready0 c=%0d got=%b exp=%b", name, c, req0_ready, ep[c] == 0); end
      n_checks++; if (req1_ready !== (ep[c] == 1)) begin n_fail++; $display("FAIL %s ready1 c=%0d got=%b exp=%b", name, c, req1_ready, ep[c] == 1); end
      if (ep[c] == 0) begin
        n_checks++; if ({sbox_X_s0, sbox_X_s1, sbox_Fresh} !== {b0 ^ m0, m0, 8'hC0 + 8'(c)}) begin n_fail++; $display("FAIL %s drive0 c=%0d got=%h exp=%h", name, c, {sbox_X_s0, sbox_X_s1, sbox_Fresh}, {b0 ^ m0, m0, 8'hC0 + 8'(c)}); end
      end else if (ep[c] == 1) begin
        n_checks++; if ({sbox_X_s0, sbox_X_s1, sbox_Fresh} !== {b1 ^ m1, m1, 8'hC0 + 8'(c)}) begin n_fail++; $display("FAIL %s drive1 c=%0d got=%h exp=%h", name, c, {sbox_X_s0, sbox_X_s1, sbox_Fresh}, {b1 ^ m1, m1, 8'hC0 + 8'(c)}); end
      end else begin
        n_checks++; if ({sbox_X_s0, sbox_X_s1, sbox_Fresh, fresh_ack} !== 25'h0) begin n_fail++; $display("FAIL %s drive_none c=%0d got=%h exp=0", name, c, {sbox_X_s0, sbox_X_s1, sbox_Fresh, fresh_ack}); end
      end
      k = c - LAT;
      e0 = 1'b0; e1 = 1'b0;
      if (k >= 0 && ev[k]) begin e0 = (ep[k] == 0); e1 = (ep[k] == 1); end
      n_checks++; if ({rsp0_valid, rsp1_valid} !== {e0, e1}) begin n_fail++; $display("FAIL %s rsp_valid c=%0d got=%b exp=%b", name, c, {rsp0_valid, rsp1_valid}, {e0, e1}); end
      if (e0 || e1) begin
        got  = e0 ? (rsp0_s0 ^ rsp0_s1) : (rsp1_s0 ^ rsp1_s1);
        gtag = e0 ? rsp0_tag : rsp1_tag;
        n_checks++; if (got !== eb[k]) begin n_fail++; $display("FAIL %s rsp_data c=%0d got=%h exp=%h", name, c, got, eb[k]); end
        n_checks++; if (gtag !== et[k]) begin n_fail++; $display("FAIL %s rsp_tag c=%0d got=%0d exp=%0d", name, c, gtag, et[k]); end
      end
    end
  endtask

  task automatic test_contention();
    int   g  [8] = '{0, 1, 0, 1, -1, -1, -1, -1};
    logic fv [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    test_stream("contention", 4, g, fv);
  endtask

  task automatic test_starvation();
    int   g  [8] = '{0, 1, -1, -1, 0, 1, -1, -1};
    logic fv [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    test_stream("starvation", 6, g, fv);
  endtask

  task automatic test_reset_midflight();
    reset_dut();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive_idle();
      rst = (c == 2);
      if (c < 2) begin
        req0_valid = 1'b1; req0_s0 = 8'h12; req0_s1 = 8'h34; req0_tag = 4'd5;
        req1_valid = 1'b1; req1_s0 = 8'h56; req1_s1 = 8'h78; req1_tag = 4'd6;
        fresh_valid = 1'b1; fresh = 8'h9A;
      end
      #2;
      if (c == 1) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midflight busy_before got=%b exp=1", busy); end
      end else if (c >= 2) begin
        n_checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL midflight c=%0d rsp_busy got=%b exp=000", c, {rsp0_valid, rsp1_valid, busy}); end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] mask [256];
    logic [7:0] got;
    int k, p, bad_rdy, bad_data;
    bad_rdy = 0; bad_data = 0;
    reset_dut();
    for (int c = 0; c < 256 + LAT; c++) begin
      @(negedge clk);
      drive_idle();
      if (c < 256) begin
        mask[c] = 8'($urandom);
        fresh_valid = 1'b1; fresh = 8'($urandom);
        if (c % 2 == 0) begin
          req0_valid = 1'b1; req0_s0 = 8'(c) ^ mask[c]; req0_s1 = mask[c]; req0_tag = 4'(c);
        end else begin
          req1_valid = 1'b1; req1_s0 = 8'(c) ^ mask[c]; req1_s1 = mask[c]; req1_tag = 4'(c);
        end
      end
      #2;
      if (c < 256) begin
        n_checks++;
        if ({req0_ready, req1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_fail++; bad_rdy++;
          if (bad_rdy < 4) $display("FAIL b2b ready c=%0d got=%b", c, {req0_ready, req1_ready});
        end
      end
      k = c - LAT;
      if (k >= 0) begin
        p = k % 2;
        got = (p == 0) ? (rsp0_s0 ^ rsp0_s1) : (rsp1_s0 ^ rsp1_s1);
        n_checks++;
        if ({rsp0_valid, rsp1_valid} !== ((p == 0) ? 2'b10 : 2'b01) || got !== aes_sbox(8'(k))
            || ((p == 0) ? rsp0_tag : rsp1_tag) !== 4'(k)) begin
          n_fail++; bad_data++;
          if (bad_data < 4) $display("FAIL b2b rsp k=%0d got=%h exp=%h valid=%b", k, got, aes_sbox(8'(k)), {rsp0_valid, rsp1_valid});
        end
      end
    end
  endtask

  task automatic test_idle();
    reset_dut();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive_idle();
      req0_s0 = 8'hA0 + 8'(c); req0_s1 = 8'h5F; req1_s0 = 8'hC7; req1_s1 = 8'h39 + 8'(c);
      fresh_valid = 1'b1; fresh = 8'hFF;
      #2;
      n_checks++; if ({sbox_X_s0, sbox_X_s1, sbox_Fresh} !== 24'h0) begin n_fail++; $display("FAIL idle drive c=%0d got=%h exp=0", c, {sbox_X_s0, sbox_X_s1, sbox_Fresh}); end
      n_checks++; if ({req0_ready, req1_ready, fresh_ack} !== 3'b000) begin n_fail++; $display("FAIL idle handshake c=%0d got=%b exp=000", c, {req0_ready, req1_ready, fresh_ack}); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_starvation();
    test_reset_midflight();
    test_back_to_back();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
